// File: rtl/register_file.sv
// 16 x 32-bit register file with two combinational read ports, one write port and a commit counter.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module register_file #(
    parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
    parameter logic [31:0] RA_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        is_ret,
    input  logic        is_st,
    input  logic [31:0] wb_data,
    input  logic [3:0]  wb_rd,
    input  logic        wb_en,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  rs1_addr,
    output logic [3:0]  rs2_addr,
    output logic [15:0] wr_count
);

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    // ret reads the link register; st reads the value to store from the rd field
    always_comb begin
        rs1_addr = is_ret ? 4'd15 : instruction[21:18];
        rs2_addr = is_st  ? instruction[25:22] : instruction[17:14];
    end

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wb_en) begin
            regs_d[wb_rd] = wb_data;
            wr_count_d    = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[14] <= SP_INIT;
            regs_q[15] <= RA_INIT;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        op1 = regs_q[rs1_addr];
        op2 = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && !rst && (wb_rd == rs1_addr)) begin
            op1 = wb_data;
        end
        if (wb_en && !rst && (wb_rd == rs2_addr)) begin
            op2 = wb_data;
        end
`else
        // without forwarding, hazard logic stalls one extra cycle instead
`endif
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset image, write/read, ret/st decode,
// same-cycle write visibility, reset-vs-write priority and counter wrap.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        is_ret;
    logic        is_st;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_en;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] wr_count;

    int checks;
    int failures;

    register_file dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .is_ret      (is_ret),
        .is_st       (is_st),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_en       (wb_en),
        .op1         (op1),
        .op2         (op2),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [3:0] rd, input logic [3:0] rs1,
                                             input logic [3:0] rs2);
        return {6'd0, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        instruction = '0;
        is_ret      = 1'b0;
        is_st       = 1'b0;
        wb_data     = '0;
        wb_rd       = '0;
        wb_en       = 1'b0;

        // reset image
        tick();
        rst = 1'b0;
        #1;
        check("rst_rs1_addr", {28'd0, rs1_addr}, 32'd0);
        check("rst_rs2_addr", {28'd0, rs2_addr}, 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_op2", op2, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            instruction = mk_instr(4'd0, 4'(i), 4'(i));
            #1;
            check($sformatf("rst_r%0d_p1", i), op1,
                  (i == 14) ? 32'h0000_0FFC : 32'd0);
            check($sformatf("rst_r%0d_p2", i), op2,
                  (i == 14) ? 32'h0000_0FFC : 32'd0);
        end

        // basic write r4
        wb_en   = 1'b1;
        wb_rd   = 4'd4;
        wb_data = 32'hAABB_CCDD;
        tick();
        wb_en   = 1'b0;
        instruction = mk_instr(4'd0, 4'd4, 4'd0);
        #1;
        check("wr_r4_op1", op1, 32'hAABB_CCDD);
        check("wr_r4_op2_r0", op2, 32'd0);
        check("wr_count_1", {16'd0, wr_count}, 32'd1);
        wb_data = 32'd0;
        tick();
        check("noen_r4_op1", op1, 32'hAABB_CCDD);
        check("noen_wr_count", {16'd0, wr_count}, 32'd1);

        // ret / st decode
        wb_en   = 1'b1;
        wb_rd   = 4'd15;
        wb_data = 32'h0000_0030;
        tick();
        wb_en   = 1'b0;
        is_ret  = 1'b1;
        instruction = mk_instr(4'd4, 4'd2, 4'd9);
        #1;
        check("ret_rs1_addr", {28'd0, rs1_addr}, 32'd15);
        check("ret_op1", op1, 32'h0000_0030);
        check("ret_rs2_addr", {28'd0, rs2_addr}, 32'd9);
        is_st = 1'b1;
        #1;
        check("st_rs2_addr", {28'd0, rs2_addr}, 32'd4);
        check("st_op2", op2, 32'hAABB_CCDD);
        check("retst_rs1_addr", {28'd0, rs1_addr}, 32'd15);
        is_ret = 1'b0;
        #1;
        check("st_rs1_addr", {28'd0, rs1_addr}, 32'd2);
        is_st = 1'b0;
        instruction = mk_instr(4'd0, 4'd14, 4'd14);
        #1;
        check("same_reg_op1", op1, 32'h0000_0FFC);
        check("same_reg_op2", op2, 32'h0000_0FFC);

        // same-cycle write and read of r7
        instruction = mk_instr(4'd0, 4'd7, 4'd7);
        wb_en   = 1'b1;
        wb_rd   = 4'd7;
        wb_data = 32'hCAFE_BABE;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_op1_pre", op1, 32'hCAFE_BABE);
        check("byp_op2_pre", op2, 32'hCAFE_BABE);
`else
        check("nobyp_op1_pre", op1, 32'd0);
        check("nobyp_op2_pre", op2, 32'd0);
`endif
        tick();
        wb_en = 1'b0;
        #1;
        check("r7_op1_post", op1, 32'hCAFE_BABE);
        check("r7_op2_post", op2, 32'hCAFE_BABE);
        check("wr_count_3", {16'd0, wr_count}, 32'd3);

        // reset beats a simultaneous write
        rst         = 1'b1;
        wb_en       = 1'b1;
        wb_rd       = 4'd3;
        wb_data     = 32'h1234_5678;
        instruction = mk_instr(4'd0, 4'd3, 4'd4);
        #1;
        check("rst_wr_op1_pre", op1, 32'd0);
        tick();
        rst   = 1'b0;
        wb_en = 1'b0;
        #1;
        check("rst_wr_r3", op1, 32'd0);
        check("rst_wr_r4", op2, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        instruction = mk_instr(4'd0, 4'd15, 4'd7);
        #1;
        check("rst_wr_r15", op1, 32'd0);
        check("rst_wr_r7", op2, 32'd0);

        // counter wrap: 65535 writes then one more
        wb_rd   = 4'd1;
        wb_data = 32'h0000_0055;
        wb_en   = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        wb_en = 1'b0;
        instruction = mk_instr(4'd0, 4'd1, 4'd0);
        #1;
        check("wrap_ffff", {16'd0, wr_count}, 32'h0000_FFFF);
        check("wrap_r1", op1, 32'h0000_0055);
        wb_en   = 1'b1;
        wb_data = 32'h0000_0066;
        tick();
        wb_en = 1'b0;
        #1;
        check("wrap_0000", {16'd0, wr_count}, 32'd0);
        check("wrap_r1_last", op1, 32'h0000_0066);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
